// File: rtl/ab_mutex_pkg.sv
// Shared types for the A/B mutual-exclusion driver: FSM state encoding and
// the widths of the guard and pulse down-counters.
package ab_mutex_pkg;

   typedef enum logic [1:0] {
      IDLE,
      A_ACT,
      GUARD,
      B_ACT
   } ab_state_e;

   localparam int GUARD_W = 4;
   localparam int PULSE_W = 4;

endpackage

// File: rtl/ab_pend_counter.sv
// Saturating up/down counter of queued B events. An increment at saturation
// is dropped and latches the sticky overflow flag.
module ab_pend_counter #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         inc,
   input  logic         dec,
   output logic [W-1:0] count,
   output logic         overflow
);

   localparam logic [W-1:0] MAX = '1;

   // A simultaneous inc and dec cancel out, so a full queue still accepts
   // an event in the same cycle one is issued.
   always_ff @(posedge clk) begin
      if (reset) begin
         count    <= '0;
         overflow <= 1'b0;
      end else if (inc && !dec) begin
         if (count == MAX)
            overflow <= 1'b1;
         else
            count <= count + W'(1);
      end else if (dec && !inc && (count != '0)) begin
         count <= count - W'(1);
      end
   end

endmodule

// File: rtl/ab_mutex_driver.sv
// Drives signal_a (prioritised ownership level) and signal_b (deferred event
// pulse) so that signal_b can never overlap or closely follow signal_a.
module ab_mutex_driver
   import ab_mutex_pkg::*;
#(
   parameter int GUARD_CYCLES = 1,
   parameter int B_PULSE_LEN  = 1,
   parameter int PEND_W       = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_a,
   input  logic              req_b,
   output logic              signal_a,
   output logic              signal_b,
   output logic [PEND_W-1:0] b_pending,
   output logic              b_overflow
);

   ab_state_e          state;
   logic [GUARD_W-1:0] guard_cnt;
   logic [PULSE_W-1:0] pulse_cnt;
   logic               b_start;

   // A B pulse may only start from IDLE, and only when A is not asking.
   assign b_start = (state == IDLE) && !req_a && (b_pending != '0);

   ab_pend_counter #(
      .W (PEND_W)
   ) u_pend (
      .clk      (clk),
      .reset    (reset),
      .inc      (req_b),
      .dec      (b_start),
      .count    (b_pending),
      .overflow (b_overflow)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         guard_cnt <= '0;
         pulse_cnt <= '0;
         signal_a  <= 1'b0;
         signal_b  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req_a) begin
                  state    <= A_ACT;
                  signal_a <= 1'b1;
               end else if (b_start) begin
                  state     <= B_ACT;
                  signal_b  <= 1'b1;
                  pulse_cnt <= PULSE_W'(B_PULSE_LEN - 1);
               end
            end
            A_ACT: begin
               if (!req_a) begin
                  signal_a <= 1'b0;
                  if (GUARD_CYCLES == 0) begin
                     state <= IDLE;
                  end else begin
                     state     <= GUARD;
                     guard_cnt <= GUARD_W'(GUARD_CYCLES - 1);
                  end
               end
            end
            GUARD: begin
               if (guard_cnt == '0)
                  state <= IDLE;
               else
                  guard_cnt <= guard_cnt - GUARD_W'(1);
            end
            B_ACT: begin
               // The pulse always runs its full length; req_a waits in IDLE.
               if (pulse_cnt == '0) begin
                  signal_b <= 1'b0;
                  state    <= IDLE;
               end else begin
                  pulse_cnt <= pulse_cnt - PULSE_W'(1);
               end
            end
            default: begin
               state    <= IDLE;
               signal_a <= 1'b0;
               signal_b <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ab_mutex_driver.sv
// Directed bench for ab_mutex_driver: a default instance for the queueing and
// priority scenarios, plus pulse-length 4 and 3 instances for reset/no-truncate.
module tb_ab_mutex_driver;

   logic       clk;
   logic       reset, req_a, req_b;
   logic       reset_x, req_a_x, req_b_x;
   logic       sig_a, sig_b, ovf;
   logic [3:0] pend;
   logic       sig_a4, sig_b4, ovf4;
   logic [3:0] pend4;
   logic       sig_a3, sig_b3, ovf3;
   logic [3:0] pend3;
   int         checks;
   int         errors;
   int         rises;
   logic       prev_b;

   ab_mutex_driver #(.GUARD_CYCLES(1), .B_PULSE_LEN(1), .PEND_W(4)) dut (
      .clk(clk), .reset(reset), .req_a(req_a), .req_b(req_b),
      .signal_a(sig_a), .signal_b(sig_b), .b_pending(pend), .b_overflow(ovf)
   );

   ab_mutex_driver #(.GUARD_CYCLES(1), .B_PULSE_LEN(4), .PEND_W(4)) dut4 (
      .clk(clk), .reset(reset_x), .req_a(req_a_x), .req_b(req_b_x),
      .signal_a(sig_a4), .signal_b(sig_b4), .b_pending(pend4), .b_overflow(ovf4)
   );

   ab_mutex_driver #(.GUARD_CYCLES(1), .B_PULSE_LEN(3), .PEND_W(4)) dut3 (
      .clk(clk), .reset(reset_x), .req_a(req_a_x), .req_b(req_b_x),
      .signal_a(sig_a3), .signal_b(sig_b3), .b_pending(pend3), .b_overflow(ovf3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] observed,
                        input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // The two outputs must never be high together, on any instance.
   always @(negedge clk) begin
      check("mutex_main", 32'(sig_a & sig_b), 32'd0);
      check("mutex_len4", 32'(sig_a4 & sig_b4), 32'd0);
      check("mutex_len3", 32'(sig_a3 & sig_b3), 32'd0);
   end

   initial begin
      checks  = 0;
      errors  = 0;
      reset   = 1'b1;
      req_a   = 1'b0;
      req_b   = 1'b0;
      reset_x = 1'b1;
      req_a_x = 1'b0;
      req_b_x = 1'b0;
      tick();
      tick();
      check("rst_sig_a", 32'(sig_a), 32'd0);
      check("rst_sig_b", 32'(sig_b), 32'd0);
      check("rst_pend", 32'(pend), 32'd0);
      check("rst_ovf", 32'(ovf), 32'd0);
      reset = 1'b0;
      tick();

      // Single queued B event issued from IDLE
      req_b = 1'b1;
      tick();
      req_b = 1'b0;
      check("t1_pend1", 32'(pend), 32'd1);
      check("t1_b_low", 32'(sig_b), 32'd0);
      tick();
      check("t1_b_high", 32'(sig_b), 32'd1);
      check("t1_pend0", 32'(pend), 32'd0);
      check("t1_a_low", 32'(sig_a), 32'd0);
      tick();
      check("t1_b_end", 32'(sig_b), 32'd0);
      tick();

      // B events deferred while A owns, then issued after the guard
      req_a = 1'b1;
      tick();
      check("t2_a_rise", 32'(sig_a), 32'd1);
      req_b = 1'b1;
      tick();
      req_b = 1'b0;
      check("t2_pend1", 32'(pend), 32'd1);
      tick();
      req_b = 1'b1;
      tick();
      req_b = 1'b0;
      check("t2_pend2", 32'(pend), 32'd2);
      check("t2_a_hold", 32'(sig_a), 32'd1);
      check("t2_b_held", 32'(sig_b), 32'd0);
      req_a = 1'b0;
      tick();
      check("t2_a_fall", 32'(sig_a), 32'd0);
      check("t2_guard_b", 32'(sig_b), 32'd0);
      tick();
      check("t2_idle_b", 32'(sig_b), 32'd0);
      tick();
      check("t2_b1_high", 32'(sig_b), 32'd1);
      check("t2_b1_pend", 32'(pend), 32'd1);
      tick();
      check("t2_b1_gap", 32'(sig_b), 32'd0);
      tick();
      check("t2_b2_high", 32'(sig_b), 32'd1);
      check("t2_b2_pend", 32'(pend), 32'd0);
      tick();
      check("t2_b2_end", 32'(sig_b), 32'd0);
      tick();

      // Simultaneous req_a and req_b: A wins, B follows after drop + guard
      req_a = 1'b1;
      req_b = 1'b1;
      tick();
      req_b = 1'b0;
      check("t3_a_rise", 32'(sig_a), 32'd1);
      check("t3_pend1", 32'(pend), 32'd1);
      check("t3_b_low0", 32'(sig_b), 32'd0);
      tick();
      check("t3_b_low1", 32'(sig_b), 32'd0);
      req_a = 1'b0;
      tick();
      check("t3_a_fall", 32'(sig_a), 32'd0);
      check("t3_b_low2", 32'(sig_b), 32'd0);
      tick();
      check("t3_b_low3", 32'(sig_b), 32'd0);
      tick();
      check("t3_b_high", 32'(sig_b), 32'd1);
      check("t3_pend0", 32'(pend), 32'd0);
      tick();
      check("t3_b_end", 32'(sig_b), 32'd0);

      // Saturation: 16 events under A leave 15 queued and overflow set
      req_a = 1'b1;
      tick();
      for (int i = 0; i < 16; i++) begin
         req_b = 1'b1;
         tick();
      end
      req_b = 1'b0;
      check("t4_pend_sat", 32'(pend), 32'd15);
      check("t4_ovf", 32'(ovf), 32'd1);
      check("t4_b_low", 32'(sig_b), 32'd0);
      req_a = 1'b0;
      tick();
      tick();
      rises  = 0;
      prev_b = 1'b0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (sig_b && !prev_b) rises++;
         prev_b = sig_b;
      end
      check("t4_pulses", 32'(rises), 32'd15);
      check("t4_pend_end", 32'(pend), 32'd0);
      check("t4_ovf_sticky", 32'(ovf), 32'd1);

      // Reset in the 2nd cycle of a 4-cycle pulse clears everything
      reset_x = 1'b0;
      req_a_x = 1'b1;
      tick();
      for (int i = 0; i < 16; i++) begin
         req_b_x = 1'b1;
         tick();
      end
      req_b_x = 1'b0;
      check("t5_ovf_set", 32'(ovf4), 32'd1);
      req_a_x = 1'b0;
      tick();
      tick();
      tick();
      check("t5_b_cyc1", 32'(sig_b4), 32'd1);
      check("t5_pend14", 32'(pend4), 32'd14);
      tick();
      check("t5_b_cyc2", 32'(sig_b4), 32'd1);
      reset_x = 1'b1;
      tick();
      check("t5_b_rst", 32'(sig_b4), 32'd0);
      check("t5_pend_rst", 32'(pend4), 32'd0);
      check("t5_ovf_rst", 32'(ovf4), 32'd0);
      check("t5_a_rst", 32'(sig_a4), 32'd0);
      reset_x = 1'b0;
      tick();
      check("t5_b_idle", 32'(sig_b4), 32'd0);

      // req_a arriving mid-pulse never truncates a 3-cycle B pulse
      req_b_x = 1'b1;
      tick();
      req_b_x = 1'b0;
      check("t6_pend1", 32'(pend3), 32'd1);
      tick();
      check("t6_b_cyc1", 32'(sig_b3), 32'd1);
      req_a_x = 1'b1;
      tick();
      check("t6_b_cyc2", 32'(sig_b3), 32'd1);
      check("t6_a_wait2", 32'(sig_a3), 32'd0);
      tick();
      check("t6_b_cyc3", 32'(sig_b3), 32'd1);
      tick();
      check("t6_b_end", 32'(sig_b3), 32'd0);
      check("t6_a_idle", 32'(sig_a3), 32'd0);
      tick();
      check("t6_a_rise", 32'(sig_a3), 32'd1);
      check("t6_b_low", 32'(sig_b3), 32'd0);
      req_a_x = 1'b0;
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
